// File: rtl/imem_boot_loader.sv
// Streams program bytes into instruction memory, then runs the CPU until it stops or times out.
// Optional LOADER_CHECKSUM_EN: accumulate an 8-bit sum of loaded bytes on checksum.
module imem_boot_loader #(
  parameter int       IMEM_DEPTH = 1024,
  parameter int       LEN_W      = 11,
  parameter int       RUN_CYCLES = 200,
  parameter bit [3:0] STAT_AOK   = 4'h1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             imem_wr_en,
  output logic [63:0]      imem_wr_addr,
  output logic [7:0]       imem_wr_data,
  output logic             cpu_valid,
  input  logic [3:0]       cpu_status,
  output logic             done,
  output logic             timeout,
  output logic [3:0]       final_status,
  output logic             len_err,
  output logic [7:0]       checksum
);

  localparam int RC_W = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, RUN, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       final_q, final_d;
  logic             wr_en_q, wr_en_d;
  logic             cpu_valid_q, cpu_valid_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             len_err_q, len_err_d;

  logic len_ok, accept, beat, last_beat;
  logic stat_exit, run_last;

  assign len_ok    = (load_len != '0) &&
                     (load_len <= LEN_W'(IMEM_DEPTH));
  assign accept    = !abort && (state_q == IDLE) &&
                     start && len_ok;
  assign beat      = !abort && s_valid && s_ready;
  assign last_beat = (bcnt_q + LEN_W'(1)) == len_q;
  assign stat_exit = cpu_status != STAT_AOK;
  assign run_last  = rcnt_q == RC_W'(RUN_CYCLES - 1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = LOAD;
        LOAD:    if (beat && last_beat) state_d = SETTLE;
        SETTLE:  state_d = RUN;
        RUN:     if (stat_exit || run_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes default low; datapath and results hold unless a state updates them.
  always_comb begin
    len_d       = len_q;
    bcnt_d      = bcnt_q;
    addr_d      = addr_q;
    rcnt_d      = rcnt_q;
    data_d      = data_q;
    final_d     = final_q;
    timeout_d   = timeout_q;
    wr_en_d     = 1'b0;
    cpu_valid_d = 1'b0;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
    if (abort) begin
      bcnt_d = '0;
      rcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !len_ok) len_err_d = 1'b1;
          if (accept) begin
            len_d     = load_len;
            bcnt_d    = '0;
            timeout_d = 1'b0;
            final_d   = '0;
          end
        end
        LOAD: begin
          if (beat) begin
            wr_en_d = 1'b1;
            addr_d  = bcnt_q;
            data_d  = s_data;
            bcnt_d  = bcnt_q + LEN_W'(1);
          end
        end
        SETTLE: begin
          cpu_valid_d = 1'b1;
          rcnt_d      = '0;
        end
        RUN: begin
          if (stat_exit || run_last) begin
            final_d   = cpu_status;
            timeout_d = !stat_exit;
            done_d    = 1'b1;
            rcnt_d    = '0;
          end else begin
            cpu_valid_d = 1'b1;
            rcnt_d      = rcnt_q + RC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      bcnt_q      <= '0;
      addr_q      <= '0;
      rcnt_q      <= '0;
      data_q      <= '0;
      final_q     <= '0;
      timeout_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      cpu_valid_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      addr_q      <= addr_d;
      rcnt_q      <= rcnt_d;
      data_q      <= data_d;
      final_q     <= final_d;
      timeout_q   <= timeout_d;
      wr_en_q     <= wr_en_d;
      cpu_valid_q <= cpu_valid_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    if (accept)                     cs_d = '0;
    else if (beat && state_q == LOAD) cs_d = cs_q + s_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cs_q <= '0;
    else        cs_q <= cs_d;
  end

  assign checksum = cs_q;
`else
  assign checksum = '0;
`endif

  assign s_ready      = (state_q == LOAD);
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = 64'(addr_q);
  assign imem_wr_data = data_q;
  assign cpu_valid    = cpu_valid_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign final_status = final_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: length-check table, write scoreboard,
// and hand-written run/abort/reset sequences.
module tb_imem_boot_loader;

  localparam int RUN_CYCLES = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [10:0] load_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready, imem_wr_en;
  logic [63:0] imem_wr_addr;
  logic [7:0]  imem_wr_data;
  logic        cpu_valid;
  logic [3:0]  cpu_status;
  logic        done, timeout, len_err;
  logic [3:0]  final_status;
  logic [7:0]  checksum;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [10:0] len;
    logic        err;
  } vec_t;
  vec_t tbl[4];

  logic [63:0] exp_addr;
  logic [7:0]  exp_sum;

  imem_boot_loader #(.RUN_CYCLES(RUN_CYCLES)) dut (
    .sys_clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready),
    .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .cpu_valid(cpu_valid),
    .cpu_status(cpu_status),
    .done(done), .timeout(timeout),
    .final_status(final_status),
    .len_err(len_err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Write monitor: every strobe must match the oldest driven beat.
  always @(negedge clk) begin
    if (rst_n && imem_wr_en) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", imem_wr_addr, w.a);
        chk("wr_data", 64'(imem_wr_data), 64'(w.d));
      end
    end
  end

  task automatic do_start(input logic [10:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
    exp_addr = '0;
    exp_sum  = '0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      s_valid = 1'b0;
      tick();
    end
    chk("s_ready_load", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = b;
    wq.push_back('{a: exp_addr, d: b});
    exp_addr++;
    exp_sum += b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic chk_sum(input string nm);
`ifdef LOADER_CHECKSUM_EN
    chk(nm, 64'(checksum), 64'(exp_sum));
`else
    chk(nm, 64'(checksum), 64'd0);
`endif
  endtask

  initial begin
    int n, cyc;
    bit seen;
    logic [7:0] b4[4];

    tbl[0] = '{len: 11'd0,    err: 1'b1};
    tbl[1] = '{len: 11'd1025, err: 1'b1};
    tbl[2] = '{len: 11'd2047, err: 1'b1};
    tbl[3] = '{len: 11'd1024, err: 1'b0};
    b4[0] = 8'h30; b4[1] = 8'hF3;
    b4[2] = 8'h0A; b4[3] = 8'h00;

    start = 0; abort = 0; load_len = 0;
    s_valid = 0; s_data = 0; cpu_status = 4'h1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_outs", {imem_wr_en, s_ready, cpu_valid, done,
                     timeout, len_err, final_status,
                     checksum, imem_wr_data}, '0);
    chk("rst_addr", imem_wr_addr, 64'd0);
    rst_n = 1'b1;
    tick();

    // Length checks from the table
    for (int i = 0; i < 4; i++) begin
      do_start(tbl[i].len);
      chk($sformatf("len_err[%0d]", i), 64'(len_err), 64'(tbl[i].err));
      chk($sformatf("s_ready[%0d]", i), 64'(s_ready), 64'(!tbl[i].err));
      if (!tbl[i].err) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else begin
        tick();
      end
      chk($sformatf("len_err_clr[%0d]", i), 64'(len_err), 64'd0);
      chk($sformatf("s_ready_idle[%0d]", i), 64'(s_ready), 64'd0);
    end

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1; load_len = 11'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_sready", 64'(s_ready), 64'd0);
    tick();

    // 4 bytes back-to-back, then status exit on 5th RUN cycle
    do_start(11'd4);
    for (int i = 0; i < 4; i++) send(b4[i], 1'b0);
    chk("settle_sready", 64'(s_ready), 64'd0);
    chk("settle_cpuv", 64'(cpu_valid), 64'd0);
    tick();
    chk("run_cpuv_rise", 64'(cpu_valid), 64'd1);
    chk_sum("checksum_4");
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("run_cpuv_hold", 64'(cpu_valid), 64'd1);
    end
    cpu_status = 4'h2;
    tick();
    cpu_status = 4'h1;
    chk("stat_cpuv_fall", 64'(cpu_valid), 64'd0);
    chk("stat_done", 64'(done), 64'd1);
    chk("stat_final", 64'(final_status), 64'd2);
    chk("stat_timeout", 64'(timeout), 64'd0);
    tick();
    chk("stat_done_once", 64'(done), 64'd0);
    chk("wq_empty_4", 64'(wq.size()), 64'd0);

    // 3 bytes with gaps, then timeout run
    do_start(11'd3);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    chk("gap_settle_sready", 64'(s_ready), 64'd0);
    tick();
    n = 0; seen = 0;
    for (cyc = 0; cyc < RUN_CYCLES + 20; cyc++) begin
      if (cpu_valid) n++;
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("to_done_seen", 64'(seen), 64'd1);
    chk("to_cpuv_cycles", 64'(n), 64'(RUN_CYCLES));
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_final", 64'(final_status), 64'd1);
    chk_sum("checksum_3");
    chk("wq_empty_3", 64'(wq.size()), 64'd0);
    tick();

    // abort during RUN
    do_start(11'd1);
    send(8'h5A, 1'b0);
    tick(); tick(); tick();
    chk("ab_run_cpuv", 64'(cpu_valid), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_cpuv", 64'(cpu_valid), 64'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) seen = 1;
      tick();
    end
    chk("ab_no_done", 64'(seen), 64'd0);
    chk("ab_timeout_clr", 64'(timeout), 64'd0);
    chk_sum("checksum_abort");

    // async reset mid-LOAD after 3 beats
    do_start(11'd8);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h04;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 64'(imem_wr_en), 64'd0);
    chk("arst_sready", 64'(s_ready), 64'd0);
    chk("arst_addr", imem_wr_addr, 64'd0);
    chk("arst_misc", {cpu_valid, done, timeout, len_err,
                      final_status, checksum, imem_wr_data}, '0);
    tick(); tick();
    s_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_no_write", 64'(imem_wr_en), 64'd0);
    chk("wq_empty_rst", 64'(wq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
